// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO feeding a frame serializer with
// configurable data width, parity and stop bits.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_data       word to queue (DATA_BITS wide)
//   in_valid      in_data valid this cycle
//   in_ready      FIFO can accept a word (not full)
//   clr_overflow  synchronous clear of the sticky overflow flag
//   tx            serial line, idle high
//   full, empty   FIFO occupancy flags
//   level         FIFO occupancy
//   overflow      sticky: a write was attempted while full
//   idle          serializer idle and FIFO empty
//   state_out     serializer state code
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned DELAY_FRAMES = 2812,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [DATA_BITS-1:0]                 in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 clr_overflow,
  output logic                                 tx,
  output logic                                 full,
  output logic                                 empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      level,
  output logic                                 overflow,
  output logic                                 idle,
  output logic [2:0]                           state_out
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned TMR_W = $clog2(DELAY_FRAMES);
  localparam int unsigned BIT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 ready_q, ready_d;
  logic                 ovf_q, ovf_d;
  logic                 idle_q, idle_d;

  // Serializer
  state_e               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  logic                 push;
  logic                 pop;
  logic                 load;
  logic                 tick;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  assign push     = in_valid && !full_q;
  assign tick     = (timer_q == TMR_W'(DELAY_FRAMES - 1));
  assign head     = mem_q[rd_ptr_q];
  // Even parity is the XOR of the data bits; odd parity is its inverse.
  assign head_par = (PARITY == 1) ? ~(^head) : (^head);

  // Serializer next-state: the load path is shared by IDLE and back-to-back STOP
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    load    = 1'b0;

    if (state_q != S_IDLE) begin
      timer_d = tick ? '0 : timer_q + TMR_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (!empty_q) load = 1'b1;
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            if (!empty_q) load = 1'b1;
            else          state_d = S_IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d = S_START;
      timer_d = '0;
      shift_d = head;
      par_d   = head_par;
    end
  end

  assign pop = load;

  // Line level follows the state being entered so tx changes on the same edge
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // FIFO pointers, occupancy flags and sticky overflow
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + LVL_W'(push) - LVL_W'(pop);
    full_d   = (count_d == LVL_W'(FIFO_DEPTH));
    empty_d  = (count_d == '0);
    ready_d  = !full_d;
    idle_d   = (state_d == S_IDLE) && empty_d;
    ovf_d    = ovf_q;
    if (in_valid && full_q) ovf_d = 1'b1;
    else if (clr_overflow)  ovf_d = 1'b0;
  end

  // Storage array carries no reset; only written entries are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ready_q  <= 1'b1;
      ovf_q    <= 1'b0;
      idle_q   <= 1'b1;
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
      idle_q   <= idle_d;
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
    end
  end

  assign in_ready  = ready_q;
  assign tx        = tx_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign level     = count_q;
  assign overflow  = ovf_q;
  assign idle      = idle_q;
  assign state_out = state_q;

endmodule
